// File: rtl/reg_cmd_bridge_pkg.sv
// Shared constants and parser state encoding for the UART register bridge.
// Holds frame header/trailer, reply header, command codes and reply checksum.
package reg_cmd_bridge_pkg;

    localparam logic [7:0] HDR1   = 8'hAB;
    localparam logic [7:0] HDR2   = 8'hBA;
    localparam logic [7:0] TRL1   = 8'h55;
    localparam logic [7:0] TRL2   = 8'h56;
    localparam logic [7:0] RPL1   = 8'hC5;
    localparam logic [7:0] RPL2   = 8'hC3;
    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    typedef enum logic [3:0] {
        ST_H1,
        ST_H2,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_T1,
        ST_T2,
        ST_EXEC,
        ST_TX
    } state_t;

    function automatic logic [7:0] reply_chk(
        input logic [7:0]  addr,
        input logic [31:0] word
    );
        return addr ^ word[31:24] ^ word[23:16]
                    ^ word[15:8]  ^ word[7:0];
    endfunction

endpackage

// File: rtl/reg_tx_serializer.sv
// 8-byte read-reply buffer driven out over a valid/ready byte handshake.
// Ports: load+addr+word start a reply; tx_* handshake; done on last transfer.
module reg_tx_serializer
    import reg_cmd_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [7:0]  addr,
    input  logic [31:0] word,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        done
);

    // Bytes 2..8 of the reply, next one in the top byte.
    logic [55:0] rest;
    logic [2:0]  cnt;
    logic        xfer;

    assign xfer = tx_valid && tx_ready;
    assign done = xfer && (cnt == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data  <= '0;
            tx_valid <= 1'b0;
            rest     <= '0;
            cnt      <= '0;
        end else if (load) begin
            tx_data  <= RPL1;
            rest     <= {RPL2, addr, word, reply_chk(addr, word)};
            tx_valid <= 1'b1;
            cnt      <= '0;
        end else if (xfer) begin
            if (cnt == 3'd7) begin
                tx_valid <= 1'b0;
            end else begin
                tx_data <= rest[55:48];
                rest    <= {rest[47:0], 8'h00};
                cnt     <= cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/reg_cmd_bridge.sv
// UART byte-stream command parser: writes/reads a 32-bit register bank.
// Ports: i_rx_* in, o_tx_*/i_tx_ready reply, o_regs/i_regs banks, strobes.
module reg_cmd_bridge
    import reg_cmd_bridge_pkg::*;
#(
    parameter int NREG        = 25,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic [NREG*32-1:0] o_regs,
    input  logic [NREG*32-1:0] i_regs,
    output logic               o_wr_pulse,
    output logic [4:0]         o_wr_addr,
    output logic               o_frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t        state;
    state_t        state_nx;
    logic [7:0]    cmd_q;
    logic [7:0]    addr_q;
    logic [31:0]   data_q;
    logic [1:0]    dcnt;
    logic [TW-1:0] tmo_cnt;
    logic [31:0]   rd_word;

    logic accept;
    logic waiting;
    logic tmo;
    logic in_range;
    logic is_wr;
    logic is_rd;
    logic frame_ok;
    logic trl_bad;
    logic do_wr;
    logic exec_bad;
    logic tx_load;
    logic tx_done;

    // Bytes are only consumed while parsing; EXEC/TX drop them.
    assign accept  = i_rx_valid
                   && (state != ST_EXEC)
                   && (state != ST_TX);
    assign waiting = (state != ST_H1)
                   && (state != ST_EXEC)
                   && (state != ST_TX);
    assign tmo     = waiting && !i_rx_valid
                   && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    assign in_range = int'(addr_q) < NREG;
    assign is_wr    = cmd_q == CMD_WR;
    assign is_rd    = cmd_q == CMD_RD;

    // Frame decisions are registered on the final trailer byte so the
    // write and its strobes are visible during the EXEC cycle.
    assign frame_ok = accept && (state == ST_T2)
                    && (i_rx_data == TRL2);
    assign trl_bad  = accept
                    && (((state == ST_T1) && (i_rx_data != TRL1))
                     || ((state == ST_T2) && (i_rx_data != TRL2)));
    assign do_wr    = frame_ok && is_wr && in_range;
    assign exec_bad = frame_ok && !(is_rd || (is_wr && in_range));

    // Out-of-range reads return zero.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NREG; k++) begin
            if (int'(addr_q) == k) rd_word = i_regs[32*k +: 32];
        end
    end

    always_comb begin
        state_nx = state;
        tx_load  = 1'b0;
        unique case (state)
            ST_H1:
                if (accept && i_rx_data == HDR1) state_nx = ST_H2;
            ST_H2:
                if (accept) begin
                    if (i_rx_data == HDR2)      state_nx = ST_CMD;
                    else if (i_rx_data == HDR1) state_nx = ST_H2;
                    else                        state_nx = ST_H1;
                end
            ST_CMD:
                if (accept) state_nx = ST_ADDR;
            ST_ADDR:
                if (accept) state_nx = ST_DATA;
            ST_DATA:
                if (accept && dcnt == 2'd3) state_nx = ST_T1;
            ST_T1:
                if (accept) begin
                    state_nx = (i_rx_data == TRL1) ? ST_T2 : ST_H1;
                end
            ST_T2:
                if (accept) begin
                    state_nx = (i_rx_data == TRL2) ? ST_EXEC : ST_H1;
                end
            ST_EXEC: begin
                tx_load  = is_rd;
                state_nx = is_rd ? ST_TX : ST_H1;
            end
            ST_TX:
                if (tx_done) state_nx = ST_H1;
            default:
                state_nx = ST_H1;
        endcase
        if (tmo) state_nx = ST_H1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_H1;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            dcnt        <= '0;
            tmo_cnt     <= '0;
            o_regs      <= '0;
            o_wr_pulse  <= 1'b0;
            o_wr_addr   <= '0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_nx;
            o_wr_pulse  <= do_wr;
            o_frame_err <= trl_bad || exec_bad || tmo;

            if (accept || !waiting) tmo_cnt <= '0;
            else                    tmo_cnt <= tmo_cnt + TW'(1);

            if (accept) begin
                unique case (state)
                    ST_CMD: cmd_q <= i_rx_data;
                    ST_ADDR: begin
                        addr_q <= i_rx_data;
                        dcnt   <= '0;
                    end
                    ST_DATA: begin
                        data_q <= {data_q[23:0], i_rx_data};
                        dcnt   <= dcnt + 2'd1;
                    end
                    default: ;
                endcase
            end

            if (do_wr) o_wr_addr <= addr_q[4:0];
            for (int k = 0; k < NREG; k++) begin
                if (do_wr && int'(addr_q) == k) begin
                    o_regs[32*k +: 32] <= data_q;
                end
            end
        end
    end

    reg_tx_serializer u_tx (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (tx_load),
        .addr     (addr_q),
        .word     (rd_word),
        .tx_ready (i_tx_ready),
        .tx_data  (o_tx_data),
        .tx_valid (o_tx_valid),
        .done     (tx_done)
    );

endmodule

// File: tb/tb_reg_cmd_bridge.sv
// Randomised bench for reg_cmd_bridge with a byte-level reference model.
// Directed frames pin the model with literal expectations.
module tb_reg_cmd_bridge;

    localparam int NREG = 25;
    localparam int TMO  = 40;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         rx_data = '0;
    logic               rx_valid = 1'b0;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready = 1'b0;
    logic [NREG*32-1:0] regs_o;
    logic [NREG*32-1:0] regs_i = '0;
    logic               wr_pulse;
    logic [4:0]         wr_addr;
    logic               frame_err;

    always #5 clk = ~clk;

    reg_cmd_bridge #(.NREG(NREG), .TIMEOUT_CYC(TMO)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_regs      (regs_o),
        .i_regs      (regs_i),
        .o_wr_pulse  (wr_pulse),
        .o_wr_addr   (wr_addr),
        .o_frame_err (frame_err)
    );

    int errs   = 0;
    int checks = 0;
    int ready_mode = 0;
    int n_wr  = 0;
    int n_err = 0;
    logic [7:0] rep[$];
    logic [7:0] exp_rd [8] = '{8'hC5, 8'hC3, 8'h04, 8'hDE,
                               8'hAD, 8'hBE, 8'hEF, 8'h26};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Stage counts bytes of the frame in progress: 0 hunting, 1 saw AB,
    // 2..9 the eight bytes after the header.
    logic [31:0] m_regs [NREG];
    logic [7:0]  m_txq[$];
    int          m_stage;
    int          m_idle;
    bit          m_exec;
    logic [7:0]  m_cmd;
    logic [7:0]  m_addr;
    logic [31:0] m_data;
    bit          e_wr;
    bit          e_err;
    logic [4:0]  e_addr;

    task automatic m_reset();
        for (int k = 0; k < NREG; k++) m_regs[k] = '0;
        m_txq.delete();
        m_stage = 0; m_idle = 0; m_exec = 0;
        m_cmd = '0; m_addr = '0; m_data = '0;
        e_wr = 0; e_err = 0; e_addr = '0;
    endtask

    task automatic m_byte(input logic [7:0] b);
        case (m_stage)
            0: if (b == 8'hAB) m_stage = 1;
            1: m_stage = (b == 8'hBA) ? 2 : ((b == 8'hAB) ? 1 : 0);
            2: begin m_cmd = b; m_stage = 3; end
            3: begin m_addr = b; m_stage = 4; end
            4, 5, 6, 7: begin
                m_data = {m_data[23:0], b};
                m_stage++;
            end
            8: if (b == 8'h55) m_stage = 9;
               else begin e_err = 1; m_stage = 0; end
            default: begin
                m_stage = 0;
                if (b != 8'h56) e_err = 1;
                else begin
                    m_exec = 1;
                    if (m_cmd == 8'h01 && m_addr < NREG) begin
                        m_regs[m_addr] = m_data;
                        e_wr = 1;
                        e_addr = m_addr[4:0];
                    end else if (m_cmd != 8'h02) e_err = 1;
                end
            end
        endcase
    endtask

    task automatic m_step();
        bit busy;
        logic [31:0] w;
        busy = m_exec || (m_txq.size() > 0);
        e_wr = 0; e_err = 0;
        if (m_txq.size() > 0 && tx_ready) void'(m_txq.pop_front());
        if (m_exec) begin
            m_exec = 0;
            if (m_cmd == 8'h02) begin
                w = 32'h0;
                if (m_addr < NREG) w = regs_i[32*m_addr +: 32];
                m_txq.push_back(8'hC5);
                m_txq.push_back(8'hC3);
                m_txq.push_back(m_addr);
                m_txq.push_back(w[31:24]);
                m_txq.push_back(w[23:16]);
                m_txq.push_back(w[15:8]);
                m_txq.push_back(w[7:0]);
                m_txq.push_back(m_addr ^ w[31:24] ^ w[23:16]
                                ^ w[15:8] ^ w[7:0]);
            end
        end
        if (rx_valid && !busy) begin
            m_idle = 0;
            m_byte(rx_data);
        end else if (m_stage != 0 && !busy) begin
            m_idle++;
            if (m_idle == TMO) begin
                e_err = 1; m_stage = 0; m_idle = 0;
            end
        end
    endtask

    initial begin : model
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    // ---------------- compare process ----------------
    bit         prev_stall = 0;
    logic [7:0] prev_data  = '0;

    initial begin : compare
        logic [NREG*32-1:0] flat;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                continue;
            end
            chk("wr_pulse", wr_pulse, e_wr);
            chk("wr_addr", wr_addr, e_addr);
            chk("frame_err", frame_err, e_err);
            chk("tx_valid", tx_valid, m_txq.size() > 0);
            if (m_txq.size() > 0) chk("tx_data", tx_data, m_txq[0]);
            for (int k = 0; k < NREG; k++) flat[32*k +: 32] = m_regs[k];
            checks++;
            if (regs_o !== flat) begin
                errs++;
                for (int k = 0; k < NREG; k++) begin
                    if (regs_o[32*k +: 32] !== flat[32*k +: 32]) begin
                        $display("FAIL regs[%0d]: got %h expected %h",
                                 k, regs_o[32*k +: 32], flat[32*k +: 32]);
                        break;
                    end
                end
            end
            if (prev_stall && tx_valid) chk("tx_stable", tx_data, prev_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (tx_valid && tx_ready) rep.push_back(tx_data);
            if (wr_pulse) n_wr++;
            if (frame_err) n_err++;
        end
    end

    // ---------------- drivers ----------------
    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0)      tx_ready = 1'($urandom_range(0, 1));
            else if (ready_mode == 1) tx_ready = !tx_ready;
            else                      tx_ready = 1'b1;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) sync();
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        sync();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                              input logic [31:0] d, input logic [7:0] t2);
        logic [7:0] q [10];
        q = '{8'hAB, 8'hBA, cmd, addr, d[31:24], d[23:16],
              d[15:8], d[7:0], 8'h55, t2};
        for (int i = 0; i < 10; i++) send(q[i]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_stage != 0 || m_exec || m_txq.size() != 0 || tx_valid)
               && n < 300) begin
            sync();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errs++;
            $display("FAIL idle_wait: still busy after %0d cycles", n);
        end
    endtask

    task automatic wait_rep(input int want);
        int n;
        n = 0;
        while (rep.size() < want && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic rand_frame(input int f);
        logic [7:0]  cmd, addr, t1, t2, b;
        logic [31:0] d;
        logic [7:0]  q [10];
        int r;
        for (int k = 0; k < NREG; k++) regs_i[32*k +: 32] = $urandom;
        ready_mode = 0;
        r = $urandom_range(0, 9);
        if (r < 4)      cmd = 8'h01;
        else if (r < 8) cmd = 8'h02;
        else            cmd = 8'($urandom_range(3, 255));
        addr = 8'($urandom_range(0, 31));
        d    = $urandom;
        t1   = ($urandom_range(0, 9) == 0) ? 8'h54 : 8'h55;
        t2   = ($urandom_range(0, 9) == 0) ? 8'h57 : 8'h56;
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == 8'hAB) b = 8'h00;
            send(b);
        end
        q = '{8'hAB, 8'hBA, cmd, addr, d[31:24], d[23:16],
              d[15:8], d[7:0], t1, t2};
        for (int i = 0; i < 10; i++) begin
            idle($urandom_range(0, 3));
            send(q[i]);
            if (f % 8 == 7 && i == 3) begin
                idle(TMO + 3);
                break;
            end
        end
        if (cmd == 8'h02 && $urandom_range(0, 1) == 1) begin
            send(8'hAB); send(8'hBA); send(8'h01);
        end
        wait_idle();
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int e0, w0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_regs", regs_o == '0, 1);
        sync();
        rst = 1'b0;
        sync();

        // Register write commits one cycle after the last byte.
        send_frame(8'h01, 8'h03, 32'h12345678, 8'h56);
        @(negedge clk);
        chk("wr3_pulse", wr_pulse, 1);
        chk("wr3_addr", wr_addr, 3);
        chk("wr3_word", regs_o[3*32 +: 32], 32'h12345678);
        sync();
        wait_idle();

        // Read with a toggling ready; checksum 04^DE^AD^BE^EF = 0x26.
        regs_i[4*32 +: 32] = 32'hDEADBEEF;
        ready_mode = 1;
        rep.delete();
        send_frame(8'h02, 8'h04, 32'h0, 8'h56);
        @(negedge clk);
        chk("rd_exec_valid", tx_valid, 0);
        @(negedge clk);
        chk("rd_first_valid", tx_valid, 1);
        chk("rd_first_byte", tx_data, 8'hC5);
        wait_rep(8);
        for (int i = 0; i < 8; i++) begin
            chk("rd_reply", (i < rep.size()) ? rep[i] : 8'hxx, exp_rd[i]);
        end
        sync();
        wait_idle();

        // Bad trailer, then a good frame to the same register.
        e0 = n_err; w0 = n_wr;
        send_frame(8'h01, 8'h07, 32'h11111111, 8'h57);
        wait_idle();
        idle(2);
        chk("trl_err_count", n_err - e0, 1);
        chk("trl_wr_count", n_wr - w0, 0);
        chk("trl_word7", regs_o[7*32 +: 32], 0);
        send_frame(8'h01, 8'h07, 32'hA5A50001, 8'h56);
        wait_idle();
        chk("trl_next_word7", regs_o[7*32 +: 32], 32'hA5A50001);

        // Header resync on AB AB BA, then an out-of-range write.
        e0 = n_err; w0 = n_wr;
        send(8'hAB);
        send_frame(8'h01, 8'h1E, 32'h11223344, 8'h56);
        wait_idle();
        idle(2);
        chk("oor_err_count", n_err - e0, 1);
        chk("oor_wr_count", n_wr - w0, 0);
        chk("oor_wr_addr", wr_addr, 7);

        // Stall mid-frame until the inter-byte timeout fires.
        e0 = n_err;
        send(8'hAB); send(8'hBA); send(8'h01); send(8'h05);
        idle(TMO + 5);
        chk("tmo_err_count", n_err - e0, 1);
        send_frame(8'h01, 8'h05, 32'hCAFEF00D, 8'h56);
        wait_idle();
        chk("tmo_next_word5", regs_o[5*32 +: 32], 32'hCAFEF00D);

        // Bytes arriving during EXEC/TX are discarded.
        ready_mode = 1;
        send_frame(8'h02, 8'h05, 32'h0, 8'h56);
        send(8'hAB); send(8'hBA); send(8'h01);
        wait_idle();
        send_frame(8'h01, 8'h09, 32'h0BADF00D, 8'h56);
        wait_idle();
        chk("drop_word9", regs_o[9*32 +: 32], 32'h0BADF00D);

        for (int f = 0; f < 40; f++) rand_frame(f);

        // Reset in the middle of a reply.
        regs_i[4*32 +: 32] = 32'hDEADBEEF;
        ready_mode = 2;
        idle(2);
        rep.delete();
        send_frame(8'h02, 8'h04, 32'h0, 8'h56);
        wait_rep(2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_valid", tx_valid, 0);
        chk("mid_rst_regs", regs_o == '0, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sync();
        ready_mode = 1;
        rep.delete();
        send_frame(8'h02, 8'h04, 32'h0, 8'h56);
        wait_rep(8);
        chk("post_rst_len", rep.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("post_rst_reply", (i < rep.size()) ? rep[i] : 8'hxx,
                exp_rd[i]);
        end
        sync();
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
